// File: rtl/rx_word_aligner_pkg.sv
// rx_word_aligner shared types and constants.
// Optional statistics build: define RX_ALIGN_STATS_EN.
package rx_align_pkg;

  localparam int WORD_W = 32;
  localparam int OFF_W  = 5;

  localparam logic [WORD_W-1:0] SYNC_DEFAULT = 32'hBC3C_F0F0;

  typedef enum logic [1:0] {
    SEARCH,
    VERIFY,
    LOCKED
  } state_t;

  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rx_word_aligner_if.sv
// Word stream bundle between upstream, aligner and consumer.
// master = stimulus/consumer side, slave = aligner side.
interface rx_word_aligner_if;
  import rx_align_pkg::*;

  logic [WORD_W-1:0] din;
  logic              din_valid;
  logic [WORD_W-1:0] dout;
  logic              dout_valid;
  logic              dout_sof;

  modport master (
    output din, din_valid,
    input  dout, dout_valid, dout_sof
  );

  modport slave (
    input  din, din_valid,
    output dout, dout_valid, dout_sof
  );

endinterface

// File: rtl/rx_word_aligner_window.sv
// Two-word sliding window and 64-to-32 extraction
// at the current bit offset. Pure datapath.
module rx_align_window
  import rx_align_pkg::*;
(
  input  logic              clk,
  input  logic              rstn,
  input  logic [WORD_W-1:0] i_din,
  input  logic              i_din_valid,
  input  logic [OFF_W-1:0]  i_offset,
  output logic [WORD_W-1:0] o_aligned
);

  logic [WORD_W-1:0]   r_prev;
  logic [2*WORD_W-1:0] w_cat;

  // Keep the previous valid word; bit 0 is the oldest bit.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      r_prev <= '0;
    else if (i_din_valid)
      r_prev <= i_din;
  end

  assign w_cat     = {i_din, r_prev};
  assign o_aligned = w_cat[{1'b0, i_offset} +: WORD_W];

endmodule

// File: rtl/rx_word_aligner.sv
// Frame sync search/verify/lock and payload delivery.
// Define RX_ALIGN_STATS_EN for lock-loss/sync-miss counters.
module rx_word_aligner
  import rx_align_pkg::*;
#(
  parameter logic [WORD_W-1:0] SYNC_WORD = SYNC_DEFAULT,
  parameter int FRAME_LEN    = 16,
  parameter int LOCK_COUNT   = 4,
  parameter int UNLOCK_COUNT = 4
) (
  input  logic             clk,
  input  logic             rstn,
  rx_word_aligner_if.slave rx,
  input  logic             realign,
  output logic             locked,
  output logic [OFF_W-1:0] bit_offset
`ifdef RX_ALIGN_STATS_EN
  ,
  output logic [15:0]      lock_loss_cnt,
  output logic [15:0]      sync_miss_cnt
`endif
);

  localparam int CW = cnt_w(FRAME_LEN);
  localparam logic [CW-1:0] LAST_W = CW'(FRAME_LEN - 1);
  localparam logic [CW-1:0] ONE_W  = CW'(1);
  localparam logic [3:0] LOCK_N    = 4'(LOCK_COUNT);
  localparam logic [3:0] UNLOCK_N  = 4'(UNLOCK_COUNT);

  state_t            r_state, w_state;
  logic [OFF_W-1:0]  r_off, w_off;
  logic [CW-1:0]     r_wcnt, w_wcnt, w_wnext;
  logic [3:0]        r_good, w_good, w_ginc;
  logic [3:0]        r_miss, w_miss, w_minc;
  logic [WORD_W-1:0] r_dout, w_dout;
  logic              r_dv, w_dv;
  logic              r_sof, w_sof;
  logic              r_locked;
  logic [WORD_W-1:0] w_aligned;
  logic              w_match;
  logic              w_bnd;

  rx_align_window u_win (
    .clk         (clk),
    .rstn        (rstn),
    .i_din       (rx.din),
    .i_din_valid (rx.din_valid),
    .i_offset    (r_off),
    .o_aligned   (w_aligned)
  );

  assign w_match = (w_aligned == SYNC_WORD);
  assign w_bnd   = (r_wcnt == '0);
  assign w_wnext = (r_wcnt == LAST_W) ? '0 : r_wcnt + ONE_W;
  assign w_ginc  = r_good + 4'd1;
  assign w_minc  = r_miss + 4'd1;

  // Next state, counters and output word.
  always_comb begin
    w_state = r_state;
    w_off   = r_off;
    w_wcnt  = r_wcnt;
    w_good  = r_good;
    w_miss  = r_miss;
    w_dout  = r_dout;
    w_dv    = 1'b0;
    w_sof   = 1'b0;
    if (realign) begin
      w_state = SEARCH;
      w_wcnt  = '0;
      w_good  = '0;
      w_miss  = '0;
    end else if (rx.din_valid) begin
      unique case (r_state)
        SEARCH: begin
          if (w_match) begin
            w_wcnt  = ONE_W;
            w_good  = 4'd1;
            w_miss  = '0;
            w_state = (LOCK_COUNT == 1) ? LOCKED : VERIFY;
          end else begin
            w_off = r_off + 5'd1;
          end
        end
        VERIFY: begin
          w_wcnt = w_wnext;
          if (w_bnd && w_match) begin
            w_good = w_ginc;
            if (w_ginc == LOCK_N) begin
              w_state = LOCKED;
              w_miss  = '0;
            end
          end else if (w_bnd) begin
            w_state = SEARCH;
            w_off   = r_off + 5'd1;
            w_wcnt  = '0;
            w_good  = '0;
          end
        end
        LOCKED: begin
          w_wcnt = w_wnext;
          if (w_bnd && w_match) begin
            w_miss = '0;
          end else if (w_bnd) begin
            w_miss = w_minc;
            if (w_minc == UNLOCK_N) begin
              w_state = SEARCH;
              w_wcnt  = '0;
              w_good  = '0;
              w_miss  = '0;
            end
          end else begin
            w_dout = w_aligned;
            w_dv   = 1'b1;
            w_sof  = (r_wcnt == ONE_W);
          end
        end
        default: w_state = SEARCH;
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state  <= SEARCH;
      r_off    <= '0;
      r_wcnt   <= '0;
      r_good   <= '0;
      r_miss   <= '0;
      r_dout   <= '0;
      r_dv     <= 1'b0;
      r_sof    <= 1'b0;
      r_locked <= 1'b0;
    end else begin
      r_state  <= w_state;
      r_off    <= w_off;
      r_wcnt   <= w_wcnt;
      r_good   <= w_good;
      r_miss   <= w_miss;
      r_dout   <= w_dout;
      r_dv     <= w_dv;
      r_sof    <= w_sof;
      r_locked <= (w_state == LOCKED);
    end
  end

  assign rx.dout       = r_dout;
  assign rx.dout_valid = r_dv;
  assign rx.dout_sof   = r_sof;
  assign locked        = r_locked;
  assign bit_offset    = r_off;

`ifdef RX_ALIGN_STATS_EN
  logic [15:0] r_lloss, r_smiss;
  logic        w_lloss_ev, w_smiss_ev;

  assign w_lloss_ev = (r_state == LOCKED) && (w_state == SEARCH);
  assign w_smiss_ev = rx.din_valid && !realign && w_bnd
                   && !w_match
                   && (r_state == VERIFY || r_state == LOCKED);

  // Saturating lock-loss and sync-miss event counters.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_lloss <= '0;
      r_smiss <= '0;
    end else begin
      if (w_lloss_ev && r_lloss != 16'hFFFF)
        r_lloss <= r_lloss + 16'd1;
      if (w_smiss_ev && r_smiss != 16'hFFFF)
        r_smiss <= r_smiss + 16'd1;
    end
  end

  assign lock_loss_cnt = r_lloss;
  assign sync_miss_cnt = r_smiss;
`endif

endmodule
